// File: rtl/i2c_reg_slave_if.sv
// Bus bundle between an I2C register slave and its surroundings: raw pads,
// open-drain SDA enable, and the register-file strobe port.
// Ports: sda_in/scl_in (pads), sda_oe (pull SDA low), reg_* (register file), busy.
interface i2c_reg_slave_if;
  logic       sda_in;
  logic       scl_in;
  logic       sda_oe;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  sda_in, scl_in, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy
  );

  modport master (
    output sda_in, scl_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy
  );
endinterface

// File: rtl/i2c_reg_slave.sv
// I2C register slave: 7-bit device address, one sub-address byte loading an
// auto-incrementing register pointer, then byte writes (reg_we) or reads (reg_rd).
// Latency: pads reach edge detection after 2 clk (plus 2 with I2C_GLITCH_FILTER_EN);
// sda_oe updates on the clk after a detected SCL fall. No backpressure: the I2C
// master owns the clock, reg_rdata must be valid in the cycle reg_rd is high.
// Ports: clk, rst (sync, active-high); bus (slave modport): sda_in, scl_in,
// sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, reg_rdata, busy.
// Optional: define I2C_GLITCH_FILTER_EN to require 3 equal samples per line change.
module i2c_reg_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h70
) (
  input  logic          clk,
  input  logic          rst,
  i2c_reg_slave_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, SUB, ACK_SUB, WR, ACK_WR, RD, RACK, IGNORE
  } state_t;

  state_t     state_q;
  logic       sda_s1_q, sda_s2_q, scl_s1_q, scl_s2_q;
  logic       sda_line_q, scl_line_q;   // previous settled line values
  logic       sda_d, scl_d;             // current settled line values
  logic [7:0] sh_q;
  logic [3:0] cnt_q;
  logic       rw_q;
  logic       nak_q;
  logic       sda_oe_q;
  logic [6:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       reg_we_q;
  logic       reg_rd_q;
  logic       busy_q;

`ifdef I2C_GLITCH_FILTER_EN
  // Two extra history taps: a line only moves once three successive
  // synchronised samples agree, so pulses of 1-2 clk are swallowed.
  logic sda_h1_q, sda_h2_q, scl_h1_q, scl_h2_q;
  assign sda_d = (sda_s2_q == sda_h1_q && sda_h1_q == sda_h2_q) ? sda_s2_q : sda_line_q;
  assign scl_d = (scl_s2_q == scl_h1_q && scl_h1_q == scl_h2_q) ? scl_s2_q : scl_line_q;
`else
  assign sda_d = sda_s2_q;
  assign scl_d = scl_s2_q;
`endif

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_d & ~scl_line_q;
  assign scl_fall  = ~scl_d &  scl_line_q;
  // Bus conditions are judged against the current SCL level so that a
  // START/STOP landing in the same clk as an SCL edge wins over the data bit.
  assign start_det = ~sda_d &  sda_line_q & scl_d;
  assign stop_det  =  sda_d & ~sda_line_q & scl_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      sda_line_q  <= 1'b1;
      scl_line_q  <= 1'b1;
`ifdef I2C_GLITCH_FILTER_EN
      sda_h1_q    <= 1'b1;
      sda_h2_q    <= 1'b1;
      scl_h1_q    <= 1'b1;
      scl_h2_q    <= 1'b1;
`endif
      sh_q        <= 8'h00;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b0;
      nak_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= 7'd0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sda_s1_q   <= bus.sda_in;
      sda_s2_q   <= sda_s1_q;
      scl_s1_q   <= bus.scl_in;
      scl_s2_q   <= scl_s1_q;
      sda_line_q <= sda_d;
      scl_line_q <= scl_d;
`ifdef I2C_GLITCH_FILTER_EN
      sda_h1_q   <= sda_s2_q;
      sda_h2_q   <= sda_h1_q;
      scl_h1_q   <= scl_s2_q;
      scl_h2_q   <= scl_h1_q;
`endif
      reg_we_q <= 1'b0;
      reg_rd_q <= 1'b0;

      // Read data is captured at the end of the strobe cycle; the pointer
      // moves on the cycle after a write strobe so reg_we sees the old address.
      if (reg_rd_q) sh_q <= bus.reg_rdata;
      if (reg_we_q) reg_addr_q <= reg_addr_q + 7'd1;

      if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q  <= ADDR;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          ADDR, SUB, WR: begin
            sh_q  <= {sh_q[6:0], sda_d};
            cnt_q <= cnt_q + 4'd1;
          end
          // Fetch the first read byte during the address ACK high phase so
          // the MSB is ready to drive at the following SCL fall.
          ACK_ADDR: if (rw_q) reg_rd_q <= 1'b1;
          RD: begin
            sh_q  <= {sh_q[6:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
          end
          RACK: begin
            nak_q <= sda_d;
            if (!sda_d) begin
              reg_addr_q <= reg_addr_q + 7'd1;
              reg_rd_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          ADDR: begin
            if (cnt_q == 4'd8) begin
              if (sh_q[7:1] == DEV_ADDR) begin
                state_q  <= ACK_ADDR;
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                rw_q     <= sh_q[0];
              end else begin
                state_q  <= IGNORE;
                busy_q   <= 1'b0;
              end
            end
          end
          ACK_ADDR: begin
            cnt_q <= 4'd0;
            if (rw_q) begin
              state_q  <= RD;
              sda_oe_q <= ~sh_q[7];
            end else begin
              state_q  <= SUB;
              sda_oe_q <= 1'b0;
            end
          end
          SUB: begin
            if (cnt_q == 4'd8) begin
              reg_addr_q <= sh_q[6:0];
              state_q    <= ACK_SUB;
              sda_oe_q   <= 1'b1;
            end
          end
          ACK_SUB, ACK_WR: begin
            state_q  <= WR;
            sda_oe_q <= 1'b0;
            cnt_q    <= 4'd0;
          end
          WR: begin
            if (cnt_q == 4'd8) begin
              reg_wdata_q <= sh_q;
              reg_we_q    <= 1'b1;
              state_q     <= ACK_WR;
              sda_oe_q    <= 1'b1;
            end
          end
          RD: begin
            if (cnt_q == 4'd8) begin
              state_q  <= RACK;
              sda_oe_q <= 1'b0;
            end else begin
              sda_oe_q <= ~sh_q[7];
            end
          end
          RACK: begin
            cnt_q <= 4'd0;
            if (nak_q) begin
              state_q  <= IGNORE;
              sda_oe_q <= 1'b0;
            end else begin
              state_q  <= RD;
              sda_oe_q <= ~sh_q[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master, a register file answering
// reg_rd/reg_we, and an array model of register contents and pointer motion.
module tb_i2c_reg_slave;
  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic clk = 1'b0;
  logic rst;
  logic m_sda, m_scl;
  always #5 clk = ~clk;

  i2c_reg_slave_if bus();
  i2c_reg_slave #(.DEV_ADDR(7'h70)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] regfile   [128];
  logic [7:0] model_mem [128];
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  // Open-drain bus: the line is low if either side pulls it.
  assign bus.sda_in    = m_sda & ~bus.sda_oe;
  assign bus.scl_in    = m_scl;
  assign bus.reg_rdata = regfile[bus.reg_addr];

  logic [6:0] we_a [$];
  logic [7:0] we_d [$];
  logic [6:0] rd_a [$];
  int overlap = 0;
  int oe_cnt  = 0;
  int checks  = 0;
  int failures = 0;

  initial begin
    for (int i = 0; i < 128; i++) regfile[i] = 8'($urandom);
    forever begin
      @(negedge clk);
      if (bus.reg_we) begin
        we_a.push_back(bus.reg_addr);
        we_d.push_back(bus.reg_wdata);
        regfile[bus.reg_addr] = bus.reg_wdata;
      end
      if (bus.reg_rd) rd_a.push_back(bus.reg_addr);
      if (bus.reg_we && bus.reg_rd) overlap++;
      if (bus.sda_oe) oe_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2*Q);
  endtask

  // gbit selects a data bit whose SCL high phase carries a 2-clk low glitch.
  task automatic wr_byte(input logic [7:0] b, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1;
      if (i == gbit) begin
        tick(Q); m_scl = 1'b0; tick(2); m_scl = 1'b1; tick(Q);
      end else begin
        tick(2*Q);
      end
      m_scl = 1'b0; tick(Q);
    end
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    ack = ~bus.sda_in;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic rd_bit(output logic v);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    v = bus.sda_in;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic rd_byte(input logic nak, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) rd_bit(b[i]);
    m_sda = nak; tick(Q);
    m_scl = 1'b1; tick(2*Q);
    m_scl = 1'b0; tick(Q);
    m_sda = 1'b1;
  endtask

  task automatic do_write(input logic [6:0] ptr, input int n, output int naks);
    logic a;
    naks = 0;
    i2c_start();
    wr_byte(8'hE0, -1, a);        if (!a) naks++;
    wr_byte({1'b0, ptr}, -1, a);  if (!a) naks++;
    for (int k = 0; k < n; k++) begin
      wr_byte(wbuf[k], -1, a);    if (!a) naks++;
    end
    i2c_stop();
  endtask

  task automatic do_read(input logic [6:0] ptr, input int n, output int naks, output logic busy_mid);
    logic a;
    naks = 0;
    i2c_start();
    wr_byte(8'hE0, -1, a);        if (!a) naks++;
    wr_byte({1'b0, ptr}, -1, a);  if (!a) naks++;
    i2c_start();
    wr_byte(8'hE1, -1, a);        if (!a) naks++;
    busy_mid = bus.busy;
    for (int k = 0; k < n; k++) rd_byte(k == n - 1, rbuf[k]);
    i2c_stop();
  endtask

  // Expected writes land at consecutive pointer values, wrapping at 128.
  task automatic check_writes(input int ptr, input int n, input int base);
    check("we_count", we_a.size() - base, n);
    for (int k = 0; k < n; k++) begin
      if (base + k < we_a.size()) begin
        check("we_addr", we_a[base + k], (ptr + k) % 128);
        check("we_data", we_d[base + k], wbuf[k]);
      end
      model_mem[(ptr + k) % 128] = wbuf[k];
    end
  endtask

  task automatic check_reads(input int ptr, input int n, input int base);
    check("rd_count", rd_a.size() - base, n);
    for (int k = 0; k < n; k++) begin
      if (base + k < rd_a.size()) check("rd_addr", rd_a[base + k], (ptr + k) % 128);
      check("rd_data", rbuf[k], model_mem[(ptr + k) % 128]);
    end
  endtask

  initial begin
    int nak, base, rbase, oe0, n;
    logic bm, ack, v;
    logic [6:0] p;
    logic [7:0] b, exp_b;

    m_sda = 1'b1; m_scl = 1'b1; rst = 1'b1;
    tick(3);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_reg_addr", bus.reg_addr, 0);
    check("rst_reg_wdata", bus.reg_wdata, 0);
    check("rst_reg_we", bus.reg_we, 0);
    check("rst_reg_rd", bus.reg_rd, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick(4);
    for (int i = 0; i < 128; i++) model_mem[i] = regfile[i];

    // Sequential write with pointer auto-increment.
    base = we_a.size();
    wbuf[0] = 8'h55; wbuf[1] = 8'h1F;
    do_write(7'h0A, 2, nak);
    check("wr0a_naks", nak, 0);
    check_writes(7'h0A, 2, base);
    check("wr0a_final_ptr", bus.reg_addr, 7'h0C);
    check("wr0a_busy_after_stop", bus.busy, 0);

    // Pointer wrap 7F -> 00 -> 01.
    base = we_a.size();
    wbuf[0] = 8'hFA; wbuf[1] = 8'h4D;
    do_write(7'h7F, 2, nak);
    check("wr7f_naks", nak, 0);
    check_writes(7'h7F, 2, base);
    check("wr7f_final_ptr", bus.reg_addr, 7'h01);

    // Read across the wrap with restart, ACK, ACK, NAK.
    rbase = rd_a.size();
    do_read(7'h7E, 3, nak, bm);
    check("rd7e_naks", nak, 0);
    check("rd7e_busy_mid", bm, 1);
    check_reads(7'h7E, 3, rbase);
    check("rd7e_busy_after_stop", bus.busy, 0);

    // Random write/read-back pairs.
    for (int it = 0; it < 5; it++) begin
      p = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
      base = we_a.size();
      do_write(p, n, nak);
      check("rnd_wr_naks", nak, 0);
      check_writes(p, n, base);
      rbase = rd_a.size();
      n = $urandom_range(1, 4);
      do_read(p, n, nak, bm);
      check("rnd_rd_naks", nak, 0);
      check_reads(p, n, rbase);
    end

    // Foreign device address: no ACK, no drive, no strobes.
    base = we_a.size(); rbase = rd_a.size(); oe0 = oe_cnt;
    i2c_start();
    wr_byte(8'hE2, -1, ack);
    check("foreign_addr_ack", ack, 0);
    wr_byte(8'($urandom), -1, ack);
    i2c_stop();
    check("foreign_oe_cycles", oe_cnt - oe0, 0);
    check("foreign_we_count", we_a.size() - base, 0);
    check("foreign_rd_count", rd_a.size() - rbase, 0);
    check("foreign_busy", bus.busy, 0);

    // Reset in the middle of a read byte while the slave pulls SDA low.
    p = 7'h33;
    wbuf[0] = 8'($urandom) & 8'hEF;
    base = we_a.size();
    do_write(p, 1, nak);
    check("rstmid_prewrite_naks", nak, 0);
    check_writes(p, 1, base);
    i2c_start();
    wr_byte(8'hE0, -1, ack);
    wr_byte({1'b0, p}, -1, ack);
    i2c_start();
    wr_byte(8'hE1, -1, ack);
    check("rstmid_read_ack", ack, 1);
    for (int k = 0; k < 3; k++) rd_bit(v);
    check("rstmid_oe_before", bus.sda_oe, 1);
    rst = 1'b1;
    tick(1);
    check("rstmid_oe_after", bus.sda_oe, 0);
    check("rstmid_busy_after", bus.busy, 0);
    check("rstmid_ptr_after", bus.reg_addr, 0);
    rst = 1'b0;
    tick(2);
    i2c_stop();
    p = 7'($urandom_range(0, 127));
    wbuf[0] = 8'($urandom);
    base = we_a.size();
    do_write(p, 1, nak);
    check("rstmid_post_naks", nak, 0);
    check_writes(p, 1, base);

    // SCL low glitch during the first data bit of a written byte.
    p = 7'($urandom_range(0, 127));
    b = 8'($urandom);
`ifdef I2C_GLITCH_FILTER_EN
    exp_b = b;
`else
    exp_b = {b[7], b[7:1]};
`endif
    wbuf[0] = exp_b;
    base = we_a.size();
    i2c_start();
    wr_byte(8'hE0, -1, ack);
    check("glitch_addr_ack", ack, 1);
    wr_byte({1'b0, p}, -1, ack);
    check("glitch_sub_ack", ack, 1);
    wr_byte(b, 7, ack);
    i2c_stop();
    check_writes(p, 1, base);

    check("we_rd_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h70, the 7-bit I2C device address (wire byte 8'hE0 for write, 8'hE1 for read).
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port sda_in, input, 1 bit: the raw SDA pad input.
REQ-005 The block SHALL have port scl_in, input, 1 bit: the raw SCL pad input.
REQ-006 The block SHALL have port sda_oe, output, 1 bit: open-drain SDA pull-low enable (1 = drive 0).
REQ-007 The block SHALL have port reg_addr, output, 7 bits: the register pointer.
REQ-008 The block SHALL have port reg_wdata, output, 8 bits: the received data byte.
REQ-009 The block SHALL have port reg_we, output, 1 bit: a 1-cycle write strobe.
REQ-010 The block SHALL have port reg_rd, output, 1 bit: a 1-cycle strobe; reg_rdata is captured in the same cycle.
REQ-011 The block SHALL have port reg_rdata, input, 8 bits: register read data.
REQ-012 The block SHALL have port busy, output, 1 bit: high from START to STOP while addressed.

Function
REQ-013 sda_in and scl_in SHALL pass through 2-FF synchronisers; SCL rise/fall and SDA rise/fall SHALL be detected on the synchronised signals.
REQ-014 START/restart (SDA fall with SCL high) SHALL enter ADDR from any state with bit counter cleared; the pointer SHALL be retained.
REQ-015 STOP (SDA rise with SCL high) SHALL enter IDLE from any state, release sda_oe and drop busy.
REQ-016 Data SHALL be sampled on SCL rise; sda_oe SHALL change only on the clk cycle after an SCL fall is detected.
REQ-017 FSM states SHALL be IDLE, ADDR, ACK_ADDR, SUB, ACK_SUB, WR, ACK_WR, RD, RACK (master ack), IGNORE.
REQ-018 ADDR: after 8 bits, a match with DEV_ADDR SHALL go to ACK_ADDR (sda_oe=1 for one SCL period); a mismatch SHALL go to IGNORE (no ack) until START/STOP.
REQ-019 ACK_ADDR SHALL go to SUB when R/W=0, or load reg_rdata into the shift register, pulse reg_rd, and go to RD when R/W=1.
REQ-020 SUB: 8 bits received, the low 7 bits SHALL load into reg_addr (MSB ignored), and the block SHALL go to ACK_SUB, then WR.
REQ-021 WR: after the 8th bit, reg_wdata SHALL be updated and reg_we pulsed for 1 cycle at the SCL fall that starts ACK_WR; reg_addr SHALL increment on the next cycle; ACK_WR SHALL then return to WR.
REQ-022 RD: MSB first; sda_oe SHALL equal the inverse of the current bit; after 8 bits SDA SHALL be released and the block SHALL go to RACK.
REQ-023 RACK: master ACK (SDA=0) SHALL increment reg_addr, capture reg_rdata, pulse reg_rd, and return to RD; master NAK SHALL go to IGNORE.
REQ-024 The pointer SHALL wrap 127 -> 0 on increment.
REQ-025 START and STOP coinciding with an SCL edge in the same clk cycle SHALL take priority over the data bit.
REQ-026 reg_we and reg_rd SHALL never be asserted in the same cycle.

Reset
REQ-027 While rst=1 at a clk edge: state=IDLE, sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_rd=0, busy=0, and synchronisers SHALL be set to 1 (bus idle).
REQ-028 Reset mid-transfer SHALL release SDA at the first clk edge with rst=1; after reset the block SHALL ignore the bus until the next START.

Configuration
REQ-029 With I2C_GLITCH_FILTER_EN defined, each synchronised line SHALL change only after 3 consecutive equal samples, adding 2 cycles of edge latency.
REQ-030 Without I2C_GLITCH_FILTER_EN, synchronised lines SHALL be used directly, with 2-cycle input latency.

Verification
REQ-031 Write E0, 0A, 55, 1F, STOP -> all ACKed; reg_we pulses with (addr,data) = (0A,55) then (0B,1F); final reg_addr=0C.
REQ-032 Write E0, 7F, FA, 4D -> reg_we pulses with (7F,FA) then (00,4D); the pointer wraps to 01.
REQ-033 Write E0, 7E, restart, E1, read 3 bytes with ACK, ACK, NAK, STOP -> reg_rd pulses at pointer 7E, 7F, 00; SDA bits match reg_rdata; busy drops at STOP.
REQ-034 Write address byte E2 -> no ACK (sda_oe stays 0) and no strobes until STOP.
REQ-035 Assert rst during bit 4 of a read byte -> sda_oe=0 on the next clk edge; a following E0 transfer is ACKed normally.
REQ-036 With I2C_GLITCH_FILTER_EN defined, a 2-clk SCL low glitch during WR -> no bit shifted and no state change; without the macro -> one extra bit is shifted.
